weight_ordered_enumerator: RTL
==============================

Name: weight_ordered_enumerator

Overview:
Sequential source that enumerates every W-bit input vector exactly once, ordered by Hamming weight (class 0, then 1, …, W). Within each class, vectors come out in ascending numeric order (Gosper next-combination).
Sits directly upstream of the ones-counter stage in the LUT input-permutation enumerator: its vec output feeds the counter's vec input, and its weight output is the expected count for that stage.
Output is a valid/ready stream with no bubbles under continuous ready.

Parameters:
W, 5, vector width (legal range 1..16)
CW, log2(W+1) computed via the codebase log2 macro, width of the weight field (localparam, not overridable)

Ports:
clk  in  1  clock; all logic is rising-edge
rst  in  1  reset: synchronous, active-high
start  in  1  one-cycle request to begin a full enumeration; honoured only while busy=0
out_valid  out  1  vec/weight/index/flags are valid this cycle
out_ready  in  1  consumer accepts; a transfer occurs when out_valid & out_ready
vec  out  W  current enumerated vector
weight  out  CW  number of ones in vec (the class number)
index  out  W  sequence number of vec, 0..2^W-1
first_of_class  out  1  vec is the first (smallest) vector of its weight class
last_of_class  out  1  vec is the last (largest) vector of its weight class
last  out  1  vec is the final vector (all ones)
busy  out  1  enumeration in progress (RUN state)
done  out  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: out_valid, vec, weight, index, first_of_class, last_of_class, last, busy, done.
  - rst has priority over every other input, including mid-run: an enumeration in progress is abandoned with no done pulse.
- FSM states: IDLE, RUN.
  - IDLE: start=1 moves to RUN at the next edge. Next cycle: out_valid=1, vec=0, weight=0, index=0, first_of_class=1, last_of_class=1, busy=1. Start-to-valid latency is 1 cycle.
  - RUN: start is ignored.
  - RUN with no transfer (out_valid & !out_ready): every output holds stable.
  - RUN with a transfer: the next vector is presented in the following cycle (zero bubbles) and index increments by 1.
- Next-vector rule, applied on transfer. With v = vec and k = weight:
  - Not last_of_class: c = v & -v; r = v + c; next = r | (((r ^ v) >> 2) >> tz(v)), where tz is the trailing-zero count. This is division-free Gosper. r is computed in W+1 bits and never overflows within a class.
  - last_of_class and not last: next = (1 << (k+1)) - 1, weight = k+1, first_of_class=1.
  - last: the next state is IDLE; out_valid=0 and busy=0 in the following cycle, and done=1 for exactly that one cycle.
- Flag definitions:
  - last_of_class = 1 when vec equals k ones packed into the MSBs, i.e. ((1<<k)-1) << (W-k). This covers k=0 (vec=0) and k=W.
  - first_of_class = 1 when vec == (1<<k)-1.
  - last = 1 when k == W.
- Class sizes follow C(W,k). Total transfers per run = 2^W, with index 2^W-1 on the last transfer.
- start arriving in the same cycle as the done pulse: accepted, since the state is IDLE; a new run begins with vec=0 in the next cycle.
- vec, weight and flags come from registers; the next-vector logic is combinational from the current registers only. Nothing combinational runs from out_ready to out_valid or to the data outputs.
- Invariant: popcount(vec) == weight whenever out_valid=1.

Test Plan:
- W=5, out_ready held 1, single start:
  - 32 transfers on consecutive cycles, index 0..31.
  - Sequence begins 00000,00001,00010,00100,01000,10000,00011,00101,00110,01001,01010,01100,10001.
  - Class sizes 1,5,10,10,5,1; last vector 11111 with last=1.
  - done pulses exactly 1 cycle after the final transfer.
- Downstream check: drive vec into the ones-counter stage each transfer and require cnt == weight for all 32 vectors. Also require every 5-bit value to appear exactly once.
- Random out_ready (~50%):
  - While out_valid & !out_ready, vec/weight/index/flags stay unchanged.
  - Order and count are identical to the ready=1 run.
- Flag check, W=5: first_of_class at vectors 00000,00001,00011,00111,01111,11111; last_of_class at 00000,10000,11000,11100,11110,11111.
- start pulsed at index 7 during a run is ignored (the sequence continues). rst asserted at index 12 gives, next cycle, out_valid=0, busy=0, done=0. A fresh start then restarts from vec=0, index=0.
- W=1: start gives vec 0 then 1 (weights 0,1), both first_of_class and last_of_class, last on the second. done follows, and a back-to-back start in the done cycle restarts the sequence.

Source files
------------

// File: rtl/weight_ordered_enumerator.sv
// Streams every W-bit vector once, grouped by Hamming weight and ascending within a class.
// Next vector is division-free Gosper within a class, then jumps to the packed-LSB start of the next class.
module weight_ordered_enumerator #(
    parameter  int W  = 5,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  vec,
    output logic [CW-1:0] weight,
    output logic [W-1:0]  index,
    output logic          first_of_class,
    output logic          last_of_class,
    output logic          last,
    output logic          busy,
    output logic          done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [W-1:0]  ONE_W  = W'(1);
    localparam logic [CW-1:0] ONE_CW = CW'(1);
    localparam logic [CW-1:0] W_CW   = CW'(W);

    state_t        state_q, state_d;
    logic [W-1:0]  vec_q, vec_d;
    logic [W-1:0]  index_q, index_d;
    logic [CW-1:0] weight_q, weight_d;
    logic          first_q, first_d;
    logic          lastc_q, lastc_d;
    logic          last_q, last_d;
    logic          done_q, done_d;

    // k ones packed into the LSBs; k == W yields all ones.
    function automatic logic [W-1:0] ones_f(input logic [CW-1:0] k);
        logic [W-1:0] all1;
        all1 = '1;
        return ~(all1 << k);
    endfunction

    function automatic logic [CW-1:0] tz_f(input logic [W-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) n = CW'(i);
        end
        return n;
    endfunction

    // W bits suffice for r: within a class the add never carries out.
    function automatic logic [W-1:0] gosper_f(input logic [W-1:0] v);
        logic [W-1:0] c, r;
        c = v & (~v + ONE_W);
        r = v + c;
        return r | (((r ^ v) >> 2) >> tz_f(v));
    endfunction

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        weight_d = weight_q;
        index_d  = index_q;
        first_d  = first_q;
        lastc_d  = lastc_q;
        last_d   = last_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    vec_d    = '0;
                    weight_d = '0;
                    index_d  = '0;
                    first_d  = 1'b1;
                    lastc_d  = 1'b1;
                    last_d   = 1'b0;
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        first_d = 1'b0;
                        lastc_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        if (lastc_q) begin
                            weight_d = weight_q + ONE_CW;
                            vec_d    = ones_f(weight_d);
                        end else begin
                            vec_d    = gosper_f(vec_q);
                        end
                        index_d = index_q + ONE_W;
                        first_d = (vec_d == ones_f(weight_d));
                        lastc_d = (vec_d == (ones_f(weight_d) << (W_CW - weight_d)));
                        last_d  = (weight_d == W_CW);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            weight_q <= '0;
            index_q  <= '0;
            first_q  <= 1'b0;
            lastc_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            weight_q <= weight_d;
            index_q  <= index_d;
            first_q  <= first_d;
            lastc_q  <= lastc_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    assign out_valid      = (state_q == RUN);
    assign busy           = (state_q == RUN);
    assign vec            = vec_q;
    assign weight         = weight_q;
    assign index          = index_q;
    assign first_of_class = first_q;
    assign last_of_class  = lastc_q;
    assign last           = last_q;
    assign done           = done_q;

endmodule
